alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  ID->EX issue register feeding the ALU: decodes a MIPS instruction into the ALU opcode,
//  signed flag and operand pair, registered behind a valid/ready handshake.
//  Sits at the ID/EX boundary. Consumes instruction and register-file data; drives the
//  ALU operator/opcode inputs and EX-stage writeback metadata. Supports stall and flush.
// PARAMETERS
//  NB_DATA        32  datapath width (operands)
//  NB_ALU_OPCODE  4   ALU opcode width
//  NB_REG_ADDR    5   register address width
//  NB_COUNT       32  issued-instruction counter width
// PORTS
//  i_clock             in   1              clock, rising edge
//  i_reset             in   1              synchronous, active-high reset
//  i_valid             in   1              ID presents an instruction
//  o_ready             out  1              stage can accept this cycle
//  i_instruction       in   32             raw MIPS instruction word
//  i_rs_data           in   NB_DATA        rs register value
//  i_rt_data           in   NB_DATA        rt register value
//  i_flush             in   1              discard held and incoming instruction
//  i_ex_ready          in   1              EX consumes output this cycle
//  o_valid             out  1              output fields hold a live instruction
//  o_first_operator    out  NB_DATA        ALU operand A
//  o_second_operator   out  NB_DATA        ALU operand B
//  o_alu_opcode        out  NB_ALU_OPCODE  ALU operation
//  o_signed_operation  out  1              1 = signed add/sub
//  o_write_reg         out  NB_REG_ADDR    destination register, 0 = none
//  o_illegal           out  1              issued instruction was undecodable
//  o_issue_count       out  NB_COUNT       instructions transferred to EX
// BEHAVIOUR
//  - Reset: o_valid=0, all data outputs 0, o_illegal=0, o_issue_count=0. o_ready=1 from the first post-reset cycle.
//  - o_ready = !o_valid | i_ex_ready (combinational). Accept = i_valid & o_ready. Latency 1 cycle.
//  - Accept loads decoded fields and sets o_valid. EX transfer (o_valid & i_ex_ready) without accept clears o_valid.
//  - Stall (o_valid & !i_ex_ready): all outputs hold stable.
//  - i_flush (priority over accept): next edge o_valid=0, data outputs 0. The incoming instruction is dropped.
//    Counter still counts an EX transfer occurring in the flush cycle.
//  - Reset mid-operation: identical to reset values. Reset has priority over flush.
//  - o_issue_count increments on each EX transfer and wraps 2^NB_COUNT-1 -> 0.
//  - ALU opcodes: SLL 0000, SRAV 0001, SRL 0010, SRA 0011, SRLV 0110, NOR 0111, ADD 1000, SLT 1001,
//    SLLV 1010, SUB 1011, AND 1100, OR 1101, XOR 1110, LUI 1111.
//  - R-type (op 000000), by funct, o_write_reg=rd:
//    - Shifts, operand A = rt:
//      - SLL/SRL/SRA (00,02,03): operand B = zero-extended shamt.
//      - SLLV/SRLV/SRAV (04,06,07): operand B = {27'b0, rs[4:0]}.
//    - Others, A = rs, B = rt:
//      - ADD/SUB (20/22): signed=1. ADDU/SUBU (21/23): signed=0.
//      - AND 24, OR 25, XOR 26, NOR 27, SLT 2A.
//  - I-type, A = rs, o_write_reg = rt:
//    - ADDI 08: ADD, sign-extended imm, signed=1.
//    - ADDIU 09: ADD, sign-extended imm. SLTI 0A: SLT, sign-extended imm.
//    - ANDI 0C / ORI 0D / XORI 0E: zero-extended imm.
//    - LUI 0F: B = zero-extended imm.
//    - Loads 20-27: ADD, sign-extended imm.
//  - Stores 28-2F: ADD, sign-extended imm, o_write_reg=0.
//  - BEQ/BNE 04/05: SUB, A=rs, B=rt, o_write_reg=0.
//  - Any other op or funct: issued with o_illegal=1, opcode 0000, operands 0, o_write_reg=0.
//  - o_signed_operation=0 unless stated.
// STRUCTURE
//  - Shared package mips_isa_pkg holds ALU opcode localparams, MIPS op/funct codes and the
//    instruction field bit ranges. The ALU uses the same package.
//  - One sub-module: alu_issue_decode (combinational decode: instruction + rs/rt -> opcode,
//    signed, operands, write_reg, illegal). This module holds the register, handshake and counter.
// TESTING
//  - ADD $3,$1,$2 (0x00221820), rs=5, rt=-7, ex_ready=1 -> next cycle: valid=1, op=1000, signed=1,
//    A=5, B=0xFFFFFFF9, write_reg=3, count=1.
//  - SLL $4,$5,3 (0x000520C0), rt=0x11 -> op=0000, A=0x11, B=3, write_reg=4.
//    SRAV with rs=0x23 -> B=3.
//  - ADDI imm 0xFFFF -> B=0xFFFFFFFF, signed=1. ANDI imm 0xFFFF -> B=0x0000FFFF, op=1100.
//    LUI imm 0x1234 -> op=1111, B=0x00001234.
//  - Backpressure: issue, hold ex_ready=0 for 3 cycles with new i_valid -> o_ready=0, outputs
//    unchanged, count unchanged. Raise ex_ready -> next instruction accepted same cycle, count+1.
//  - Flush with i_valid=1 and a held instruction -> next cycle valid=0, outputs 0, incoming
//    instruction never appears. Unknown funct 0x3F -> illegal=1, op=0000.
//  - Reset asserted while stalled with count=0xFFFFFFFF -> all outputs 0.
//    Separate run: count=0xFFFFFFFF plus one transfer -> wraps to 0.

Source files
------------

// File: rtl/mips_isa_pkg.sv
// MIPS instruction field layout, op/funct codes and ALU opcode encoding.
// Shared by the issue stage and the ALU.
package mips_isa_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRAV = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0010;
  localparam logic [3:0] ALU_SRA  = 4'b0011;
  localparam logic [3:0] ALU_SRLV = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLLV = 4'b1010;
  localparam logic [3:0] ALU_SUB  = 4'b1011;
  localparam logic [3:0] ALU_AND  = 4'b1100;
  localparam logic [3:0] ALU_OR   = 4'b1101;
  localparam logic [3:0] ALU_XOR  = 4'b1110;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int RS_HI  = 25, RS_LO  = 21;
  localparam int RT_HI  = 20, RT_LO  = 16;
  localparam int RD_HI  = 15, RD_LO  = 11;
  localparam int SH_HI  = 10, SH_LO  = 6;
  localparam int FN_HI  = 5,  FN_LO  = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef enum logic [1:0] {A_ZERO, A_RS, A_RT} opa_sel_e;
  typedef enum logic [2:0] {B_ZERO, B_RT, B_SHAMT, B_RS_LOW, B_IMM_SX, B_IMM_ZX} opb_sel_e;
  typedef enum logic [1:0] {W_NONE, W_RD, W_RT} wr_sel_e;

  function automatic logic is_load(input logic [5:0] op);
    return op[5:3] == 3'b100;
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return op[5:3] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: instruction + rs/rt values -> ALU opcode,
// signed flag, operand pair, destination register and illegal flag.
module alu_issue_decode
  import mips_isa_pkg::*;
#(
  parameter int NB_DATA       = 32,
  parameter int NB_ALU_OPCODE = 4,
  parameter int NB_REG_ADDR   = 5
) (
  input  logic [31:0]              i_instruction,
  input  logic [NB_DATA-1:0]       i_rs_data,
  input  logic [NB_DATA-1:0]       i_rt_data,
  output logic [NB_DATA-1:0]       o_first_operator,
  output logic [NB_DATA-1:0]       o_second_operator,
  output logic [NB_ALU_OPCODE-1:0] o_alu_opcode,
  output logic                     o_signed_operation,
  output logic [NB_REG_ADDR-1:0]   o_write_reg,
  output logic                     o_illegal
);

  logic [5:0]  opc, funct;
  logic [4:0]  rt_addr, rd_addr, shamt;
  logic [15:0] imm;
  logic [4:0]  unused_rs_addr;

  assign opc            = i_instruction[OP_HI:OP_LO];
  assign funct          = i_instruction[FN_HI:FN_LO];
  assign rt_addr        = i_instruction[RT_HI:RT_LO];
  assign rd_addr        = i_instruction[RD_HI:RD_LO];
  assign shamt          = i_instruction[SH_HI:SH_LO];
  assign imm            = i_instruction[IMM_HI:IMM_LO];
  assign unused_rs_addr = i_instruction[RS_HI:RS_LO];

  logic [ALU_OP_W-1:0] alu_op;
  logic                sgn, ill;
  opa_sel_e            a_sel;
  opb_sel_e            b_sel;
  wr_sel_e             w_sel;

  always_comb begin
    alu_op = ALU_SLL;
    sgn    = 1'b0;
    ill    = 1'b0;
    a_sel  = A_ZERO;
    b_sel  = B_ZERO;
    w_sel  = W_NONE;
    case (opc)
      OP_RTYPE: begin
        w_sel = W_RD;
        a_sel = A_RS;
        b_sel = B_RT;
        case (funct)
          FN_SLL:  begin alu_op = ALU_SLL;  a_sel = A_RT; b_sel = B_SHAMT;  end
          FN_SRL:  begin alu_op = ALU_SRL;  a_sel = A_RT; b_sel = B_SHAMT;  end
          FN_SRA:  begin alu_op = ALU_SRA;  a_sel = A_RT; b_sel = B_SHAMT;  end
          FN_SLLV: begin alu_op = ALU_SLLV; a_sel = A_RT; b_sel = B_RS_LOW; end
          FN_SRLV: begin alu_op = ALU_SRLV; a_sel = A_RT; b_sel = B_RS_LOW; end
          FN_SRAV: begin alu_op = ALU_SRAV; a_sel = A_RT; b_sel = B_RS_LOW; end
          FN_ADD:  begin alu_op = ALU_ADD;  sgn = 1'b1; end
          FN_ADDU: alu_op = ALU_ADD;
          FN_SUB:  begin alu_op = ALU_SUB;  sgn = 1'b1; end
          FN_SUBU: alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_NOR:  alu_op = ALU_NOR;
          FN_SLT:  alu_op = ALU_SLT;
          default: begin
            ill   = 1'b1;
            a_sel = A_ZERO;
            b_sel = B_ZERO;
            w_sel = W_NONE;
          end
        endcase
      end
      OP_ADDI:  begin alu_op = ALU_ADD; sgn = 1'b1; a_sel = A_RS; b_sel = B_IMM_SX; w_sel = W_RT; end
      OP_ADDIU: begin alu_op = ALU_ADD; a_sel = A_RS; b_sel = B_IMM_SX; w_sel = W_RT; end
      OP_SLTI:  begin alu_op = ALU_SLT; a_sel = A_RS; b_sel = B_IMM_SX; w_sel = W_RT; end
      OP_ANDI:  begin alu_op = ALU_AND; a_sel = A_RS; b_sel = B_IMM_ZX; w_sel = W_RT; end
      OP_ORI:   begin alu_op = ALU_OR;  a_sel = A_RS; b_sel = B_IMM_ZX; w_sel = W_RT; end
      OP_XORI:  begin alu_op = ALU_XOR; a_sel = A_RS; b_sel = B_IMM_ZX; w_sel = W_RT; end
      OP_LUI:   begin alu_op = ALU_LUI; a_sel = A_RS; b_sel = B_IMM_ZX; w_sel = W_RT; end
      OP_BEQ, OP_BNE: begin alu_op = ALU_SUB; a_sel = A_RS; b_sel = B_RT; end
      default: begin
        // Loads and stores both compute the effective address; only loads write back.
        if (is_load(opc)) begin
          alu_op = ALU_ADD; a_sel = A_RS; b_sel = B_IMM_SX; w_sel = W_RT;
        end else if (is_store(opc)) begin
          alu_op = ALU_ADD; a_sel = A_RS; b_sel = B_IMM_SX;
        end else begin
          ill = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    case (a_sel)
      A_RS:    o_first_operator = i_rs_data;
      A_RT:    o_first_operator = i_rt_data;
      default: o_first_operator = '0;
    endcase
    case (b_sel)
      B_RT:     o_second_operator = i_rt_data;
      B_SHAMT:  o_second_operator = {{(NB_DATA-5){1'b0}}, shamt};
      B_RS_LOW: o_second_operator = {{(NB_DATA-5){1'b0}}, i_rs_data[4:0]};
      B_IMM_SX: o_second_operator = {{(NB_DATA-16){imm[15]}}, imm};
      B_IMM_ZX: o_second_operator = {{(NB_DATA-16){1'b0}}, imm};
      default:  o_second_operator = '0;
    endcase
    case (w_sel)
      W_RD:    o_write_reg = NB_REG_ADDR'(rd_addr);
      W_RT:    o_write_reg = NB_REG_ADDR'(rt_addr);
      default: o_write_reg = '0;
    endcase
  end

  assign o_alu_opcode       = NB_ALU_OPCODE'(alu_op);
  assign o_signed_operation = sgn;
  assign o_illegal          = ill;

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EX issue register: decoded ALU fields held behind a valid/ready
// handshake with stall, flush and an issued-instruction counter.
module alu_issue_stage
  import mips_isa_pkg::*;
#(
  parameter int NB_DATA       = 32,
  parameter int NB_ALU_OPCODE = 4,
  parameter int NB_REG_ADDR   = 5,
  parameter int NB_COUNT      = 32
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [31:0]              i_instruction,
  input  logic [NB_DATA-1:0]       i_rs_data,
  input  logic [NB_DATA-1:0]       i_rt_data,
  input  logic                     i_flush,
  input  logic                     i_ex_ready,
  output logic                     o_valid,
  output logic [NB_DATA-1:0]       o_first_operator,
  output logic [NB_DATA-1:0]       o_second_operator,
  output logic [NB_ALU_OPCODE-1:0] o_alu_opcode,
  output logic                     o_signed_operation,
  output logic [NB_REG_ADDR-1:0]   o_write_reg,
  output logic                     o_illegal,
  output logic [NB_COUNT-1:0]      o_issue_count
);

  logic [NB_DATA-1:0]       dec_a, dec_b;
  logic [NB_ALU_OPCODE-1:0] dec_op;
  logic                     dec_sgn, dec_ill;
  logic [NB_REG_ADDR-1:0]   dec_wr;

  alu_issue_decode #(
    .NB_DATA(NB_DATA), .NB_ALU_OPCODE(NB_ALU_OPCODE), .NB_REG_ADDR(NB_REG_ADDR)
  ) u_decode (
    .i_instruction     (i_instruction),
    .i_rs_data         (i_rs_data),
    .i_rt_data         (i_rt_data),
    .o_first_operator  (dec_a),
    .o_second_operator (dec_b),
    .o_alu_opcode      (dec_op),
    .o_signed_operation(dec_sgn),
    .o_write_reg       (dec_wr),
    .o_illegal         (dec_ill)
  );

  logic                     valid_q, valid_d;
  logic [NB_DATA-1:0]       a_q, a_d, b_q, b_d;
  logic [NB_ALU_OPCODE-1:0] op_q, op_d;
  logic                     sgn_q, sgn_d, ill_q, ill_d;
  logic [NB_REG_ADDR-1:0]   wr_q, wr_d;
  logic [NB_COUNT-1:0]      cnt_q, cnt_d;
  logic                     accept, ex_xfer;

  assign o_ready = !valid_q || i_ex_ready;
  assign accept  = i_valid && o_ready;
  assign ex_xfer = valid_q && i_ex_ready;

  always_comb begin
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    sgn_d   = sgn_q;
    ill_d   = ill_q;
    wr_d    = wr_q;
    // A transfer in the flush cycle already left the stage, so it still counts.
    cnt_d   = cnt_q + {{(NB_COUNT-1){1'b0}}, ex_xfer};
    if (i_flush) begin
      valid_d = 1'b0;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      sgn_d   = 1'b0;
      ill_d   = 1'b0;
      wr_d    = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      a_d     = dec_a;
      b_d     = dec_b;
      op_d    = dec_op;
      sgn_d   = dec_sgn;
      ill_d   = dec_ill;
      wr_d    = dec_wr;
    end else if (ex_xfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      ill_q   <= 1'b0;
      wr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      ill_q   <= ill_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_valid            = valid_q;
  assign o_first_operator   = a_q;
  assign o_second_operator  = b_q;
  assign o_alu_opcode       = op_q;
  assign o_signed_operation = sgn_q;
  assign o_write_reg        = wr_q;
  assign o_illegal          = ill_q;
  assign o_issue_count      = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: decode vector table through a scoreboard, plus
// backpressure, flush, counter wrap and reset-while-stalled sequences.
module tb_alu_issue_stage;

  typedef struct {
    logic [31:0] instr, rs, rt;
    logic [3:0]  op;
    logic        sgn;
    logic [31:0] a, b;
    logic [4:0]  wr;
    logic        ill;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rst_small, rst2;
  logic        i_valid, i_flush, i_ex_ready;
  logic [31:0] i_instr, i_rs, i_rt;

  logic        rdy, vld, sgn, ill;
  logic [31:0] a, b, cnt;
  logic [3:0]  op;
  logic [4:0]  wr;

  logic        s_rdy, s_vld, s_sgn, s_ill;
  logic [31:0] s_a, s_b;
  logic [3:0]  s_op;
  logic [4:0]  s_wr;
  logic [2:0]  s_cnt;

  int total = 0;
  int bad   = 0;
  vec_t sb_q[$];
  vec_t tv[15];

  always #5 clk = ~clk;
  assign rst2 = rst | rst_small;

  alu_issue_stage dut (
    .i_clock(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(rdy),
    .i_instruction(i_instr), .i_rs_data(i_rs), .i_rt_data(i_rt),
    .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_valid(vld),
    .o_first_operator(a), .o_second_operator(b), .o_alu_opcode(op),
    .o_signed_operation(sgn), .o_write_reg(wr), .o_illegal(ill),
    .o_issue_count(cnt)
  );

  // Narrow counter copy so wrap and reset-at-max are reachable quickly.
  alu_issue_stage #(.NB_COUNT(3)) dut_small (
    .i_clock(clk), .i_reset(rst2), .i_valid(i_valid), .o_ready(s_rdy),
    .i_instruction(i_instr), .i_rs_data(i_rs), .i_rt_data(i_rt),
    .i_flush(i_flush), .i_ex_ready(i_ex_ready), .o_valid(s_vld),
    .o_first_operator(s_a), .o_second_operator(s_b), .o_alu_opcode(s_op),
    .o_signed_operation(s_sgn), .o_write_reg(s_wr), .o_illegal(s_ill),
    .o_issue_count(s_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, rs, rt, input logic [3:0] op,
                              input logic sg, input logic [31:0] a, b,
                              input logic [4:0] wr, input logic il);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.op = op; v.sgn = sg;
    v.a = a; v.b = b; v.wr = wr; v.ill = il;
    return v;
  endfunction

  // Scoreboard: every EX transfer must match the oldest accepted instruction.
  always @(negedge clk) begin
    if (!rst && vld && i_ex_ready) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_issue", 64'(vld), 64'(0));
      end else begin
        vec_t e;
        e = sb_q.pop_front();
        chk("sb_opcode", 64'(op), 64'(e.op));
        chk("sb_signed", 64'(sgn), 64'(e.sgn));
        chk("sb_op_a", 64'(a), 64'(e.a));
        chk("sb_op_b", 64'(b), 64'(e.b));
        chk("sb_write_reg", 64'(wr), 64'(e.wr));
        chk("sb_illegal", 64'(ill), 64'(e.ill));
      end
    end
  end

  task automatic drive(input vec_t v);
    i_instr = v.instr; i_rs = v.rs; i_rt = v.rt;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted v.
  task automatic issue(input vec_t v);
    int n;
    i_valid = 1'b1;
    drive(v);
    n = 0;
    @(negedge clk);
    while (!rdy && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (!rdy) chk("issue_timeout", 64'(rdy), 64'(1));
    else if (!i_flush) sb_q.push_back(v);
    @(posedge clk); #1;
    i_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0]  = mk(32'h00221820, 32'd5, 32'hFFFFFFF9, 4'b1000, 1, 32'd5, 32'hFFFFFFF9, 5'd3, 0);
    tv[1]  = mk(32'h000520C0, 32'd0, 32'h11, 4'b0000, 0, 32'h11, 32'd3, 5'd4, 0);
    tv[2]  = mk(32'h01073007, 32'h23, 32'h80000000, 4'b0001, 0, 32'h80000000, 32'd3, 5'd6, 0);
    tv[3]  = mk(32'h2029FFFF, 32'd10, 32'd0, 4'b1000, 1, 32'd10, 32'hFFFFFFFF, 5'd9, 0);
    tv[4]  = mk(32'h304AFFFF, 32'h12345678, 32'd0, 4'b1100, 0, 32'h12345678, 32'h0000FFFF, 5'd10, 0);
    tv[5]  = mk(32'h3C0B1234, 32'd0, 32'd0, 4'b1111, 0, 32'd0, 32'h00001234, 5'd11, 0);
    tv[6]  = mk(32'h00646023, 32'd100, 32'd30, 4'b1011, 0, 32'd100, 32'd30, 5'd12, 0);
    tv[7]  = mk(32'h8CADFFFC, 32'h1000, 32'd0, 4'b1000, 0, 32'h1000, 32'hFFFFFFFC, 5'd13, 0);
    tv[8]  = mk(32'hACCE0008, 32'h2000, 32'd0, 4'b1000, 0, 32'h2000, 32'd8, 5'd0, 0);
    tv[9]  = mk(32'h10220010, 32'd7, 32'd9, 4'b1011, 0, 32'd7, 32'd9, 5'd0, 0);
    tv[10] = mk(32'h0022183F, 32'd5, 32'd6, 4'b0000, 0, 32'd0, 32'd0, 5'd0, 1);
    tv[11] = mk(32'hFC000000, 32'd5, 32'd6, 4'b0000, 0, 32'd0, 32'd0, 5'd0, 1);
    tv[12] = mk(32'h0022782A, 32'hFFFFFFFF, 32'd1, 4'b1001, 0, 32'hFFFFFFFF, 32'd1, 5'd15, 0);
    tv[13] = mk(32'h28708000, 32'd0, 32'd0, 4'b1001, 0, 32'd0, 32'hFFFF8000, 5'd16, 0);
    tv[14] = mk(32'h00228827, 32'hF0, 32'h0F, 4'b0111, 0, 32'hF0, 32'h0F, 5'd17, 0);

    rst = 1'b1; rst_small = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ex_ready = 1'b1;
    i_instr = '0; i_rs = '0; i_rt = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 64'(vld), 64'(0));
    chk("rst_ready", 64'(rdy), 64'(1));
    chk("rst_a", 64'(a), 64'(0));
    chk("rst_b", 64'(b), 64'(0));
    chk("rst_op", 64'(op), 64'(0));
    chk("rst_wr_ill_sgn", 64'({wr, ill, sgn}), 64'(0));
    chk("rst_count", 64'(cnt), 64'(0));
    chk("rst_small_count", 64'(s_cnt), 64'(0));

    for (int k = 0; k < 15; k++) issue(tv[k]);
    @(posedge clk); #1;
    chk("table_count", 64'(cnt), 64'(15));
    chk("table_small_count", 64'(s_cnt), 64'(7));

    issue(tv[6]);
    @(posedge clk); #1;
    chk("wrap_count", 64'(cnt), 64'(16));
    chk("wrap_small_count", 64'(s_cnt), 64'(0));

    // Backpressure: tv[0] held for 3 cycles while tv[1] waits.
    i_valid = 1'b1; drive(tv[0]);
    @(negedge clk); sb_q.push_back(tv[0]);
    @(posedge clk); #1;
    i_ex_ready = 1'b0; drive(tv[1]);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_ready", 64'(rdy), 64'(0));
      chk("stall_valid", 64'(vld), 64'(1));
      chk("stall_a", 64'(a), 64'(5));
      chk("stall_b", 64'(b), 64'(32'hFFFFFFF9));
      chk("stall_op", 64'(op), 64'(4'b1000));
      chk("stall_count", 64'(cnt), 64'(16));
      @(posedge clk); #1;
    end
    i_ex_ready = 1'b1;
    @(negedge clk);
    chk("unstall_ready", 64'(rdy), 64'(1));
    sb_q.push_back(tv[1]);
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("unstall_count", 64'(cnt), 64'(17));
    chk("unstall_a", 64'(a), 64'(32'h11));
    @(posedge clk); #1;
    chk("drain_count", 64'(cnt), 64'(18));
    chk("drain_valid", 64'(vld), 64'(0));

    // Flush with a held instruction transferring and a new one arriving.
    issue(tv[2]);
    i_valid = 1'b1; i_flush = 1'b1; drive(tv[3]);
    @(posedge clk); #1;
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_valid", 64'(vld), 64'(0));
    chk("flush_a", 64'(a), 64'(0));
    chk("flush_b", 64'(b), 64'(0));
    chk("flush_op_wr", 64'({op, wr, sgn, ill}), 64'(0));
    chk("flush_count", 64'(cnt), 64'(19));
    @(posedge clk); #1;
    chk("flush_dropped", 64'(vld), 64'(0));

    // Bring the narrow counter to its maximum, stall, then reset it.
    for (int k = 3; k < 7; k++) issue(tv[k]);
    @(posedge clk); #1;
    chk("pre_rst_count", 64'(cnt), 64'(23));
    chk("pre_rst_small_count", 64'(s_cnt), 64'(7));
    issue(tv[7]);
    i_ex_ready = 1'b0;
    @(negedge clk);
    chk("held_small_valid", 64'(s_vld), 64'(1));
    chk("held_small_count", 64'(s_cnt), 64'(7));
    rst_small = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid", 64'(s_vld), 64'(0));
    chk("midrst_ready", 64'(s_rdy), 64'(1));
    chk("midrst_a", 64'(s_a), 64'(0));
    chk("midrst_b", 64'(s_b), 64'(0));
    chk("midrst_fields", 64'({s_op, s_wr, s_sgn, s_ill}), 64'(0));
    chk("midrst_count", 64'(s_cnt), 64'(0));
    rst_small = 1'b0;
    i_ex_ready = 1'b1;
    @(posedge clk); #1;
    chk("final_count", 64'(cnt), 64'(24));
    chk("final_valid", 64'(vld), 64'(0));
    chk("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
